// File: rtl/kw_fifo_stream_skid_if.sv
// Ready/valid stream bundle: one beat moves on a clock edge where valid and ready are both high.
// The master drives the payload, and the slave answers with ready.
interface kw_fifo_stream_skid_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/kw_fifo_stream_skid.sv
// Ready/valid stream FIFO that keeps accepting beats for SKID cycles after ready falls.
// With OUT_REG=1 the head of the queue is held in a dedicated output flop ahead of a DEPTH-1 ring.
module kw_fifo_stream_skid #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 16,
  parameter  int SKID       = 1,
  parameter  int OUT_REG    = 0,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  kw_fifo_stream_skid_if.slave   up,
  kw_fifo_stream_skid_if.master  dn,
  output logic [CW-1:0]          count,
  output logic                   overflow
);

  if (DEPTH < 2 || SKID < 0 || SKID >= DEPTH || DATA_WIDTH < 1) begin : g_bad_params
    $error("kw_fifo_stream_skid: illegal DEPTH/SKID/DATA_WIDTH combination");
  end

  localparam int             RING    = (OUT_REG != 0) ? DEPTH - 1 : DEPTH;
  localparam int             PW      = (RING > 1) ? $clog2(RING) : 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  SKID_C  = CW'(SKID);
  localparam logic [PW-1:0]  LAST_C  = PW'(RING - 1);

  logic [DATA_WIDTH-1:0] mem [RING];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  ring_wr;
  logic                  ring_rd;

  // Acceptance ignores up.ready. Late beats fill the reserved skid entries.
  assign full     = (count == DEPTH_C);
  assign pop      = dn.valid & dn.ready;
  assign push     = up.valid & (!full | pop);
  assign up.ready = (DEPTH_C - count) > SKID_C;

  // The explicit wrap keeps a non-power-of-two ring from aliasing.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (up.valid & full & !pop) overflow <= 1'b1;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (ring_wr) wr_ptr <= wrap_inc(wr_ptr);
        if (ring_rd) rd_ptr <= wrap_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: storage has no reset. Contents are only ever read behind a valid count or flag.
  always_ff @(posedge clock) begin
    if (ring_wr && !flush && !reset) mem[wr_ptr] <= up.data;
  end

  if (OUT_REG == 0) begin : g_comb_out
    assign ring_wr  = push;
    assign ring_rd  = pop;
    assign dn.valid = (count != '0);
    assign dn.data  = mem[rd_ptr];
  end else begin : g_reg_out
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_valid;
    logic                  ring_empty;
    logic                  flop_load;
    logic                  to_flop;

    // The ring only holds entries while the output flop is occupied.
    assign ring_empty = (count == CW'(out_valid));
    assign flop_load  = pop | !out_valid;
    assign ring_rd    = flop_load & !ring_empty;
    assign to_flop    = flop_load & ring_empty & push;
    assign ring_wr    = push & !to_flop;

    always_ff @(posedge clock) begin
      if (reset || flush) begin
        out_valid <= 1'b0;
      end else if (flop_load) begin
        if (!ring_empty) begin
          out_q     <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (push) begin
          out_q     <= up.data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end

    assign dn.valid = out_valid;
    assign dn.data  = out_q;
  end

endmodule
